// File: rtl/isq_square.sv
// Sequential squarer: shift-and-add multiply of root by itself, one multiplier
// bit per cycle (LSB first), result latched into square after WIDTH RUN cycles.
module isq_square #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     root,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   square
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   square_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 accept_s;
    logic                 last_s;
    logic [2*WIDTH-1:0]   addend_s;
    logic [2*WIDTH-1:0]   acc_next_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign square = square_r;

    // Accept decode and the partial product for the current multiplier bit.
    always_comb begin
        accept_s   = 1'b0;
        addend_s   = {(2*WIDTH){1'b0}};
        last_s     = 1'b0;
        if ((state_r == IDLE) || (state_r == DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
        if (mplier_r[0]) begin
            addend_s = {{WIDTH{1'b0}}, mcand_r} << cnt_r;
        end else begin
            addend_s = {(2*WIDTH){1'b0}};
        end
        if (cnt_r == CW'(WIDTH - 1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
        acc_next_s = acc_r + addend_s;
    end

    // FSM, datapath and registered status outputs; busy/done track the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            square_r <= {(2*WIDTH){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        mcand_r  <= root;
                        mplier_r <= root;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        square_r <= acc_next_s;
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        state_r  <= RUN;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isq_square.sv
// Directed bench for isq_square at WIDTH=16: reset, latency, corner operands,
// start-in-RUN immunity, reset abort, back-to-back throughput and random roots.
module tb_isq_square;

    logic        clk;
    logic        rst;
    logic [15:0] root;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] square;

    int pass_cnt = 0;
    int total_cnt = 0;

    isq_square #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .root   (root),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .square (square)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept r, then wait (bounded) for done; lat = cycles from accept, -1 on timeout.
    task automatic run_op(input logic [15:0] r, output logic [31:0] sq, output int lat);
        root  = r;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        sq = square;
        if (done !== 1'b1) lat = -1;
    endtask

    function automatic logic [15:0] isqrt32(input logic [31:0] n);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, n}) r = t;
        end
        return r[15:0];
    endfunction

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        root  = 16'hFFFF;
        step();
        step();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || square !== 32'd0)
            $display("FAIL reset: busy=%b done=%b square=%h, want 0/0/00000000", busy, done, square);
        else pass_cnt++;
        start = 1'b0;
        rst   = 1'b1;
        step();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle: busy=%b done=%b, want 0/0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int busy_cycles;
        int done_early;
        int n;
        busy_cycles = 0;
        done_early  = 0;
        n = 0;
        root  = 16'h0000;
        start = 1'b1;
        step();
        start = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) done_early++;
            step();
            n++;
        end
        total_cnt++;
        if (busy_cycles != 16 || n != 16)
            $display("FAIL zero_latency: busy_cycles=%0d done_after=%0d, want 16/16", busy_cycles, n);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || square !== 32'h0000_0000)
            $display("FAIL zero_result: done=%b busy=%b square=%h, want 1/0/00000000", done, busy, square);
        else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_pulse: done=%b busy=%b after DONE, want 0/0", done, busy);
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [15:0] r_v [4];
        logic [31:0] e_v [4];
        logic [31:0] sq;
        int lat;
        r_v = '{16'hFFFF, 16'h00FF, 16'h0100, 16'h8000};
        e_v = '{32'hFFFE_0001, 32'h0000_FE01, 32'h0001_0000, 32'h4000_0000};
        for (int i = 0; i < 4; i++) begin
            run_op(r_v[i], sq, lat);
            total_cnt++;
            if (sq !== e_v[i] || lat != 16)
                $display("FAIL vector_%0d: root=%h square=%h lat=%0d, want %h lat=16", i, r_v[i], sq, lat, e_v[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        logic [31:0] sq;
        dones = 0;
        sq = 32'hDEAD_BEEF;
        step();
        root  = 16'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        root  = 16'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        root  = 16'd0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                dones++;
                sq = square;
            end
            step();
        end
        total_cnt++;
        if (dones != 1)
            $display("FAIL start_in_run_dones: got %0d done pulses, want 1", dones);
        else pass_cnt++;
        total_cnt++;
        if (sq !== 32'h0000_0009 || square !== 32'h0000_0009)
            $display("FAIL start_in_run_square: got %h/%h, want 00000009", sq, square);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int dones;
        logic [31:0] sq;
        int lat;
        dones = 0;
        root  = 16'h1234;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || square !== 32'd0)
            $display("FAIL abort_async: busy=%b done=%b square=%h, want 0/0/00000000", busy, done, square);
        else pass_cnt++;
        step();
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) dones++;
            step();
        end
        total_cnt++;
        if (dones != 0 || square !== 32'd0 || busy !== 1'b0)
            $display("FAIL abort_quiet: dones=%0d square=%h busy=%b, want 0/00000000/0", dones, square, busy);
        else pass_cnt++;
        run_op(16'd2, sq, lat);
        total_cnt++;
        if (sq !== 32'h0000_0004 || lat != 16)
            $display("FAIL abort_recover: square=%h lat=%0d, want 00000004 lat=16", sq, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] sq;
        int lat;
        int gap;
        step();
        run_op(16'd5, sq, lat);
        total_cnt++;
        if (sq !== 32'h0000_0019 || lat != 16)
            $display("FAIL b2b_first: square=%h lat=%0d, want 00000019 lat=16", sq, lat);
        else pass_cnt++;
        root  = 16'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        root  = 16'd0;
        total_cnt++;
        if (busy !== 1'b1 || square !== 32'h0000_0019)
            $display("FAIL b2b_hold: busy=%b square=%h, want 1/00000019", busy, square);
        else pass_cnt++;
        gap = 1;
        while (done !== 1'b1 && gap < 40) begin
            step();
            gap++;
        end
        total_cnt++;
        if (gap != 17 || square !== 32'h0000_0031)
            $display("FAIL b2b_second: gap=%0d square=%h, want 17/00000031", gap, square);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] r;
        logic [31:0] sq;
        logic [31:0] n;
        logic [63:0] nxt;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            r = 16'($urandom_range(0, 65535));
            run_op(r, sq, lat);
            if (sq !== {16'd0, r} * {16'd0, r} || lat != 16) begin
                if (bad < 5)
                    $display("FAIL random_square: root=%h square=%h lat=%0d, want %h", r, sq, lat, {16'd0, r} * {16'd0, r});
                bad++;
            end
        end
        total_cnt++;
        if (bad != 0) $display("FAIL random_summary: %0d bad of 150, want 0", bad);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            n = $urandom;
            r = isqrt32(n);
            run_op(r, sq, lat);
            nxt = ({48'd0, r} + 64'd1) * ({48'd0, r} + 64'd1);
            if (lat != 16 || sq > n || {32'd0, n} >= nxt) begin
                if (bad < 5)
                    $display("FAIL roundtrip: n=%h isqrt=%h square=%h, want square<=n<%h", n, r, sq, nxt);
                bad++;
            end
        end
        total_cnt++;
        if (bad != 0) $display("FAIL roundtrip_summary: %0d bad of 60, want 0", bad);
        else pass_cnt++;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        root  = 16'd0;
        test_reset();
        test_zero();
        test_vectors();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
